// File: rtl/hack_kbd_adapter.sv
// hack_kbd_adapter: translates MiSTer ps2_key events into the Hack KBD register code.
// Define HACK_KBD_CAPSLOCK_EN to enable caps-lock tracking and caps_led.
module hack_kbd_adapter #(
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  output logic [15:0] kbd_code,
  output logic        kbd_strobe,
  output logic        caps_led
);

  localparam int unsigned CW = $clog2(STACK_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_UPDATE
  } state_e;

  state_e        state_q, state_d;
  logic [10:0]   key_s1_q, key_s2_q;
  logic [1:0]    arm_q;
  logic          tog_ref_q, tog_ref_d;
  logic          ev_make_q, ev_make_d;
  logic [8:0]    ev_key_q, ev_key_d;
  logic [8:0]    stk_q [STACK_DEPTH];
  logic [8:0]    stk_d [STACK_DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          shl_q, shl_d, shr_q, shr_d, caps_q, caps_d;
  logic [7:0]    code_q, code_d;
  logic          strobe_q, strobe_d;

  logic          event_w;
  logic          hit;
  int unsigned   hit_idx;
  logic [8:0]    top;
  logic          shift_w, upper_w, mapped_w;

  // {ext, scancode} -> Hack code; 0 means unmapped.
  function automatic logic [7:0] map_key(input logic [8:0] key, input logic shift,
                                         input logic upper);
    logic [7:0] lc;
    logic [7:0] r;
    lc = '0;
    r  = '0;
    if (key[8]) begin
      case (key[7:0])
        8'h5A: r = 8'd128;
        8'h6B: r = 8'd130;
        8'h75: r = 8'd131;
        8'h74: r = 8'd132;
        8'h72: r = 8'd133;
        8'h6C: r = 8'd134;
        8'h69: r = 8'd135;
        8'h7D: r = 8'd136;
        8'h7A: r = 8'd137;
        8'h70: r = 8'd138;
        8'h71: r = 8'd139;
        default: r = '0;
      endcase
    end else begin
      case (key[7:0])
        8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
        8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
        8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
        8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
        8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
        8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
        8'h35: lc = "y";  8'h1A: lc = "z";
        8'h16: r = shift ? "!" : "1";
        8'h1E: r = shift ? "@" : "2";
        8'h26: r = shift ? "#" : "3";
        8'h25: r = shift ? "$" : "4";
        8'h2E: r = shift ? "%" : "5";
        8'h36: r = shift ? "^" : "6";
        8'h3D: r = shift ? "&" : "7";
        8'h3E: r = shift ? "*" : "8";
        8'h46: r = shift ? "(" : "9";
        8'h45: r = shift ? ")" : "0";
        8'h0E: r = shift ? "~" : 8'h60;
        8'h4E: r = shift ? "_" : "-";
        8'h55: r = shift ? "+" : "=";
        8'h54: r = shift ? "{" : "[";
        8'h5B: r = shift ? "}" : "]";
        8'h5D: r = shift ? "|" : "\\";
        8'h4C: r = shift ? ":" : ";";
        8'h52: r = shift ? "\"" : "'";
        8'h41: r = shift ? "<" : ",";
        8'h49: r = shift ? ">" : ".";
        8'h4A: r = shift ? "?" : "/";
        8'h29: r = " ";
        8'h5A: r = 8'd128;
        8'h66: r = 8'd129;
        8'h76: r = 8'd140;
        8'h05: r = 8'd141;  8'h06: r = 8'd142;  8'h04: r = 8'd143;  8'h0C: r = 8'd144;
        8'h03: r = 8'd145;  8'h0B: r = 8'd146;  8'h83: r = 8'd147;  8'h0A: r = 8'd148;
        8'h01: r = 8'd149;  8'h09: r = 8'd150;  8'h78: r = 8'd151;  8'h07: r = 8'd152;
        default: r = '0;
      endcase
      if (lc != '0) r = upper ? lc - 8'd32 : lc;
    end
    return r;
  endfunction

  // Reference is primed from the input pipe for two cycles after reset, so the
  // level already present on ps2_key[10] is not taken as an event.
  assign event_w = (arm_q == 2'd2) && (key_s2_q[10] != tog_ref_q);

  always_comb begin
    state_d   = state_q;
    tog_ref_d = tog_ref_q;
    ev_make_d = ev_make_q;
    ev_key_d  = ev_key_q;
    stk_d     = stk_q;
    cnt_d     = cnt_q;
    shl_d     = shl_q;
    shr_d     = shr_q;
    caps_d    = caps_q;
    code_d    = code_q;
    strobe_d  = 1'b0;
    hit       = 1'b0;
    hit_idx   = 0;
    top       = '0;
    shift_w   = 1'b0;
    upper_w   = 1'b0;
    mapped_w  = map_key(ev_key_q, 1'b0, 1'b0) != 8'h00;

    if (arm_q != 2'd2) tog_ref_d = key_s1_q[10];

    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (i < 32'(cnt_q) && stk_q[i] == ev_key_q) begin
        hit     = 1'b1;
        hit_idx = i;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (event_w) begin
          tog_ref_d = key_s2_q[10];
          ev_make_d = key_s2_q[9];
          ev_key_d  = key_s2_q[8:0];
          state_d   = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        if (!ev_key_q[8] && ev_key_q[7:0] == 8'h12) begin
          shl_d = ev_make_q;
        end else if (!ev_key_q[8] && ev_key_q[7:0] == 8'h59) begin
          shr_d = ev_make_q;
`ifdef HACK_KBD_CAPSLOCK_EN
        end else if (!ev_key_q[8] && ev_key_q[7:0] == 8'h58) begin
          if (ev_make_q) caps_d = !caps_q;
`endif
        end else if (mapped_w) begin
          if (ev_make_q) begin
            if (!hit) begin
              if (cnt_q == CW'(STACK_DEPTH)) begin
                for (int unsigned i = 0; i + 1 < STACK_DEPTH; i++) stk_d[i] = stk_q[i + 1];
                stk_d[STACK_DEPTH - 1] = ev_key_q;
              end else begin
                for (int unsigned i = 0; i < STACK_DEPTH; i++)
                  if (i == 32'(cnt_q)) stk_d[i] = ev_key_q;
                cnt_d = cnt_q + CW'(1);
              end
            end
          end else if (hit) begin
            for (int unsigned i = 0; i + 1 < STACK_DEPTH; i++)
              if (i >= hit_idx) stk_d[i] = stk_q[i + 1];
            cnt_d = cnt_q - CW'(1);
          end
        end

        // The code register is loaded on entry to UPDATE so it is visible there.
        for (int unsigned i = 0; i < STACK_DEPTH; i++)
          if (i + 1 == 32'(cnt_d)) top = stk_d[i];
        shift_w = shl_d | shr_d;
`ifdef HACK_KBD_CAPSLOCK_EN
        upper_w = shift_w ^ caps_d;
`else
        upper_w = shift_w;
`endif
        code_d   = (cnt_d == '0) ? 8'h00 : map_key(top, shift_w, upper_w);
        strobe_d = code_d != code_q;
        state_d  = S_UPDATE;
      end

      S_UPDATE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      key_s1_q  <= '0;
      key_s2_q  <= '0;
      arm_q     <= '0;
      tog_ref_q <= 1'b0;
      ev_make_q <= 1'b0;
      ev_key_q  <= '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
      cnt_q     <= '0;
      shl_q     <= 1'b0;
      shr_q     <= 1'b0;
      caps_q    <= 1'b0;
      code_q    <= '0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_s1_q  <= ps2_key;
      key_s2_q  <= key_s1_q;
      if (arm_q != 2'd2) arm_q <= arm_q + 2'd1;
      tog_ref_q <= tog_ref_d;
      ev_make_q <= ev_make_d;
      ev_key_q  <= ev_key_d;
      stk_q     <= stk_d;
      cnt_q     <= cnt_d;
      shl_q     <= shl_d;
      shr_q     <= shr_d;
      caps_q    <= caps_d;
      code_q    <= code_d;
      strobe_q  <= strobe_d;
    end
  end

  assign kbd_code   = {8'h00, code_q};
  assign kbd_strobe = strobe_q;
  assign caps_led   = caps_q;

endmodule

// File: tb/tb_hack_kbd_adapter.sv
// Directed self-checking bench for hack_kbd_adapter (STACK_DEPTH = 4).
module tb_hack_kbd_adapter;

`ifdef HACK_KBD_CAPSLOCK_EN
  localparam bit CAPS = 1'b1;
`else
  localparam bit CAPS = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [15:0] kbd_code;
  logic        kbd_strobe;
  logic        caps_led;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  hack_kbd_adapter #(.STACK_DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_key   (ps2_key),
    .kbd_code  (kbd_code),
    .kbd_strobe(kbd_strobe),
    .caps_led  (caps_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One key event; checks code/strobe 4 edges after the toggle and the strobe end.
  task automatic key_ev(input string tag, input logic mk, input logic ext,
                        input logic [7:0] sc, input logic [15:0] exp_code,
                        input logic exp_stb);
    @(negedge clk);
    ps2_key = {~ps2_key[10], mk, ext, sc};
    repeat (4) @(posedge clk);
    #1;
    chk({tag, " code"}, kbd_code, exp_code);
    chk({tag, " strobe"}, {15'd0, kbd_strobe}, {15'd0, exp_stb});
    @(posedge clk);
    #1;
    chk({tag, " strobe_end"}, {15'd0, kbd_strobe}, 16'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    ps2_key = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst code", kbd_code, 16'h0000);
    chk("rst strobe", {15'd0, kbd_strobe}, 16'd0);
    chk("rst caps", {15'd0, caps_led}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);

    // first make: latency check before the 4th edge
    @(negedge clk);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
    repeat (3) @(posedge clk);
    #1;
    chk("a lat3 code", kbd_code, 16'h0000);
    chk("a lat3 strobe", {15'd0, kbd_strobe}, 16'd0);
    @(posedge clk);
    #1;
    chk("a code", kbd_code, 16'h0061);
    chk("a strobe", {15'd0, kbd_strobe}, 16'd1);
    @(posedge clk);
    #1;
    chk("a strobe_end", {15'd0, kbd_strobe}, 16'd0);
    repeat (2) @(posedge clk);
    key_ev("brk a", 1'b0, 1'b0, 8'h1C, 16'h0000, 1'b1);

    key_ev("mk shl", 1'b1, 1'b0, 8'h12, 16'h0000, 1'b0);
    key_ev("A", 1'b1, 1'b0, 8'h1C, 16'h0041, 1'b1);
    key_ev("brk shl", 1'b0, 1'b0, 8'h12, 16'h0061, 1'b1);
    key_ev("brk a2", 1'b0, 1'b0, 8'h1C, 16'h0000, 1'b1);

    key_ev("enter", 1'b1, 1'b0, 8'h5A, 16'd128, 1'b1);
    key_ev("left", 1'b1, 1'b1, 8'h6B, 16'd130, 1'b1);
    key_ev("brk left", 1'b0, 1'b1, 8'h6B, 16'd128, 1'b1);
    key_ev("del", 1'b1, 1'b1, 8'h71, 16'd139, 1'b1);
    key_ev("brk del", 1'b0, 1'b1, 8'h71, 16'd128, 1'b1);
    key_ev("brk enter", 1'b0, 1'b0, 8'h5A, 16'h0000, 1'b1);

    key_ev("stk a", 1'b1, 1'b0, 8'h1C, 16'h0061, 1'b1);
    key_ev("stk b", 1'b1, 1'b0, 8'h32, 16'h0062, 1'b1);
    key_ev("stk c", 1'b1, 1'b0, 8'h21, 16'h0063, 1'b1);
    key_ev("stk d", 1'b1, 1'b0, 8'h23, 16'h0064, 1'b1);
    key_ev("stk e", 1'b1, 1'b0, 8'h24, 16'h0065, 1'b1);
    key_ev("rpt e", 1'b1, 1'b0, 8'h24, 16'h0065, 1'b0);
    key_ev("brk e", 1'b0, 1'b0, 8'h24, 16'h0064, 1'b1);
    key_ev("brk d", 1'b0, 1'b0, 8'h23, 16'h0063, 1'b1);
    key_ev("brk c", 1'b0, 1'b0, 8'h21, 16'h0062, 1'b1);
    key_ev("brk b", 1'b0, 1'b0, 8'h32, 16'h0000, 1'b1);
    key_ev("brk evicted a", 1'b0, 1'b0, 8'h1C, 16'h0000, 1'b0);

    key_ev("unm a", 1'b1, 1'b0, 8'h1C, 16'h0061, 1'b1);
    key_ev("ctrl", 1'b1, 1'b0, 8'h14, 16'h0061, 1'b0);
    key_ev("e0 4a", 1'b1, 1'b1, 8'h4A, 16'h0061, 1'b0);
    key_ev("rpt a", 1'b1, 1'b0, 8'h1C, 16'h0061, 1'b0);
    key_ev("unm brk a", 1'b0, 1'b0, 8'h1C, 16'h0000, 1'b1);

    key_ev("shr", 1'b1, 1'b0, 8'h59, 16'h0000, 1'b0);
    key_ev("bang", 1'b1, 1'b0, 8'h16, 16'h0021, 1'b1);
    key_ev("brk shr", 1'b0, 1'b0, 8'h59, 16'h0031, 1'b1);
    key_ev("brk 1", 1'b0, 1'b0, 8'h16, 16'h0000, 1'b1);
    key_ev("f12", 1'b1, 1'b0, 8'h07, 16'd152, 1'b1);
    key_ev("brk f12", 1'b0, 1'b0, 8'h07, 16'h0000, 1'b1);
    key_ev("esc", 1'b1, 1'b0, 8'h76, 16'd140, 1'b1);
    key_ev("bksp", 1'b1, 1'b0, 8'h66, 16'd129, 1'b1);
    key_ev("brk bksp", 1'b0, 1'b0, 8'h66, 16'd140, 1'b1);
    key_ev("brk esc", 1'b0, 1'b0, 8'h76, 16'h0000, 1'b1);

    key_ev("caps mk", 1'b1, 1'b0, 8'h58, 16'h0000, 1'b0);
    key_ev("caps brk", 1'b0, 1'b0, 8'h58, 16'h0000, 1'b0);
    chk("caps led", {15'd0, caps_led}, {15'd0, CAPS});
    key_ev("caps a", 1'b1, 1'b0, 8'h1C, CAPS ? 16'h0041 : 16'h0061, 1'b1);
    key_ev("caps shift a", 1'b1, 1'b0, 8'h12, CAPS ? 16'h0061 : 16'h0041, 1'b1);
    key_ev("caps brk shift", 1'b0, 1'b0, 8'h12, CAPS ? 16'h0041 : 16'h0061, 1'b1);
    key_ev("caps brk a", 1'b0, 1'b0, 8'h1C, 16'h0000, 1'b1);
    key_ev("caps mk2", 1'b1, 1'b0, 8'h58, 16'h0000, 1'b0);
    key_ev("caps brk2", 1'b0, 1'b0, 8'h58, 16'h0000, 1'b0);
    chk("caps led off", {15'd0, caps_led}, 16'd0);

    key_ev("held a", 1'b1, 1'b0, 8'h1C, 16'h0061, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async rst code", kbd_code, 16'h0000);
    chk("async rst strobe", {15'd0, kbd_strobe}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    key_ev("post rst brk a", 1'b0, 1'b0, 8'h1C, 16'h0000, 1'b0);
    key_ev("post rst b", 1'b1, 1'b0, 8'h32, 16'h0062, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hack_kbd_adapter.md
Name: hack_kbd_adapter

Overview:
- Translates MiSTer `ps2_key` events from hps_io into the 16-bit Hack keyboard code that the Nand2Tetris core reads from its KBD memory-mapped register (0x6000).
- Sits between hps_io and Nand2Tetris_top in the emu top, in the clk_sys domain.
- Tracks modifiers and a small stack of held keys, so KBD always shows the most recently pressed key that is still held, or 0 when no key is held.

Parameters:
- STACK_DEPTH, 4: number of simultaneously held non-modifier keys tracked (2..8).

Ports:
- clk  in  1  system clock (clk_sys).
- reset_n  in  1  reset, asynchronous assert, active-low.
- ps2_key  in  11  hps_io key event: [10] toggles per event, [9] 1=make/0=break, [8] E0-extended, [7:0] set-2 scancode.
- kbd_code  out  16  Hack key code for the KBD register; 0 = no key.
- kbd_strobe  out  1  one-cycle pulse whenever kbd_code changes value.
- caps_led  out  1  current caps-lock state.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - kbd_code=0, kbd_strobe=0, caps_led=0.
  - Stack empty; shift_l=shift_r=0.
  - Toggle reference = ps2_key[10] sampled through a 2-flop input register. The first post-reset cycle is not an event.
- Input stage: ps2_key passes through a 2-flop register (metastability margin, since hps_io timing is treated as loose). An event is the registered [10] differing from the stored toggle reference.
- FSM states:
  - IDLE -> CAPTURE on event; latch {make, ext, code}; update the toggle reference.
  - CAPTURE -> UPDATE: apply modifier/stack rules.
  - UPDATE -> IDLE: recompute kbd_code from stack top and modifiers.
  - Events arriving outside IDLE are taken when IDLE resumes (toggle is level-held). One toggle flip = one event.
- Latency: kbd_code and kbd_strobe are valid 4 clk edges after ps2_key[10] changes (2 input + CAPTURE + UPDATE).
- Modifiers (never pushed onto the stack):
  - 0x12 sets/clears shift_l; 0x59 sets/clears shift_r.
  - 0x58 make toggles caps; 0x58 break is ignored.
  - Ctrl 0x14 and Alt 0x11 (ext or not) are ignored.
- Stack rules for mapped non-modifier keys; entries are {ext, code} (9 bits), top = newest:
  - Make of a key already in the stack (typematic repeat): no change, no strobe.
  - Make while the stack is full: discard the oldest entry, shift the rest down, push the new key.
  - Break: remove the matching entry and compact the entries above it down. Break of an absent key: no change.
  - Unmapped scancodes: ignored entirely.
- Mapping, computed at UPDATE from the stack top; empty stack gives 0:
  - Letters: 97-122, or 65-90 when shift XOR caps.
  - Digits and punctuation: US layout ASCII; shifted glyph when shift=shift_l|shift_r. Space=32.
  - Special keys: Enter(0x5A, ext or not)=128, Backspace 0x66=129, Esc 0x76=140, F1..F12=141..152.
  - Extended keys: Left E0 6B=130, Up E0 75=131, Right E0 74=132, Down E0 72=133, Home E0 6C=134, End E0 69=135, PgUp E0 7D=136, PgDn E0 7A=137, Ins E0 70=138, Del E0 71=139.
  - kbd_code[15:8]=0 always.
- Shift change with a key held re-maps the top entry (e.g. 'a' held, shift pressed -> 65).
- kbd_strobe fires only at UPDATE and only when the new code differs from the old one.
- Reset asserted mid-sequence clears everything immediately. A key physically held across reset is not restored until a new make arrives; its later break is ignored (absent).

Optional Feature:
- Macro: HACK_KBD_CAPSLOCK_EN.
- Defined: caps-lock tracking, caps_led, and the letter-case XOR are as specified above.
- Undefined: 0x58 is treated as unmapped (ignored), caps_led is tied to 0, and letter case depends on shift only.

Test Plan:
- Reset, then make 0x1C ('a') -> kbd_code=0x0061 at edge 4 after the toggle, kbd_strobe high for exactly 1 cycle. Break 0x1C -> kbd_code=0x0000 plus strobe.
- Make 0x12, then make 0x1C -> 0x0041. Break 0x12 while 'a' is still held -> 0x0061 plus strobe.
- Make 0x5A -> 128. Make E0 6B -> 130. Break E0 6B -> back to 128. Make E0 71 -> 139.
- Press 'a' (0x1C), 'b' (0x32), 'c' (0x21), 'd' (0x23), 'e' (0x24) with STACK_DEPTH=4 -> 0x65. Break e, d, c, b in turn -> 0x64, 0x63, 0x62, then 0 ('a' was evicted). Repeated make of 'e' while held -> no strobe.
- With HACK_KBD_CAPSLOCK_EN defined: make/break 0x58 -> caps_led=1. Make 0x1C -> 0x41. Hold shift as well -> 0x61. Without the macro, the same sequence gives caps_led=0 and 0x61 then 0x41.
- Hold 'a', pull reset_n low for 1 cycle -> kbd_code=0 asynchronously. Then break 0x1C -> stays 0, no strobe.
